cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Coprocessor-0 for the 5-stage MIPS pipeline, sitting at the M stage.
- Holds SR (reg 12), Cause (reg 13) and EPC (reg 14), and samples external interrupts.
- Drives Req, the flush/redirect signal consumed by every pipeline register. Req flushes the EX/M register and loads its PC with the handler address.
- Services mtc0/mfc0 and eret from the M-stage instruction.

Parameters:
- HANDLER_PC, 32'h0000_4180: exception entry address, output on HandlerPC.
- EPC_RESET, 32'h0000_0000: reset value of EPC.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Addr  in  5  CP0 register number (Rd field of M-stage instruction)
- WriteData  in  32  mtc0 data (forwarded rt value)
- CP0Write  in  1  M-stage instruction is mtc0
- PC  in  32  M-stage PC
- BDIn  in  1  M-stage instruction is in a branch delay slot
- ExcCodeIn  in  5  pending exception code from M stage (0 = none)
- EretIn  in  1  M-stage instruction is eret
- HWInt  in  6  external interrupt lines, level-sensitive
- Req  out  1  take exception/interrupt this cycle (combinational)
- EPCOut  out  32  current EPC, target for eret
- HandlerPC  out  32  constant HANDLER_PC
- ReadData  out  32  mfc0 read value (combinational on Addr)

Behaviour:
- Reset (reset=0, asynchronous):
  - SR=0, Cause=0, EPC=EPC_RESET.
  - Req=0, because EXL=0 and IE=0.
- SR fields: IM=SR[15:10], EXL=SR[1], IE=SR[0]. All other bits store nothing and read 0.
- Cause fields: BD=Cause[31], IP=Cause[15:10], ExcCode=Cause[6:2]. All other bits read 0.
- Cause is not writable by mtc0.
- IntReq = |(HWInt & IM) & IE & ~EXL.
- ExcReq = (ExcCodeIn != 0) & ~EXL.
- Req = IntReq | ExcReq. Combinational, same cycle as the M-stage inputs.
- Every posedge: Cause.IP <= HWInt, unconditionally.
- Posedge with Req=1:
  - EXL <= 1.
  - Cause.BD <= BDIn.
  - Cause.ExcCode <= IntReq ? 0 : ExcCodeIn. Interrupts have priority over synchronous exceptions.
  - EPC <= BDIn ? PC-4 : PC, with bits [1:0] forced to 0.
- Posedge with Req=0 and EretIn=1: EXL <= 0.
- Posedge with Req=0 and CP0Write=1:
  - Addr 12 updates IM, EXL and IE from WriteData.
  - Addr 14 updates EPC with WriteData[31:2], bits [1:0] forced 0.
  - Any other Addr: no effect.
- Simultaneous events:
  - Req suppresses any mtc0 and eret in the same cycle; the M-stage instruction is being flushed.
  - eret and mtc0 cannot coincide (same stage, one instruction).
- ReadData:
  - Addr 12/13/14 returns SR/Cause/EPC, reflecting register contents before this cycle's update.
  - Any other Addr returns 0.
- EPCOut: if CP0Write=1 with Addr=14 in this cycle, returns WriteData with bits [1:0] forced 0 (bypass, so an eret directly after mtc0 EPC sees the new value). Otherwise returns the EPC register.
- Reset asserted mid-operation clears all state immediately; Req drops in the same cycle.

Optional Feature:
- Macro CP0_TIMER_EN.
- Defined:
  - Adds Count (reg 9, increments every cycle, wraps at 2^32) and Compare (reg 11). Both are readable and writable via mtc0.
  - TI flag sets on the posedge where Count+1 == Compare; cleared by any Compare write.
  - The effective interrupt line 5 becomes HWInt[5] | TI, in both IntReq and Cause.IP[15].
  - Count and Compare reset to 0.
  - An mtc0 to Count overrides that cycle's increment.
- Undefined: regs 9 and 11 read 0, writes are ignored, no TI.

Decomposition:
- Shared package:
  - Register number constants (SR=12, CAUSE=13, EPC=14, COUNT=9, COMPARE=11).
  - ExcCode constants (INT=0, ADEL=4, ADES=5, SYSCALL=8, RI=10, OV=12).
  - SR/Cause bit-position constants.
- One natural sub-module, cp0_timer: Count/Compare/TI, instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset release, all inputs 0 -> ReadData is 0 for regs 12/13/14, Req=0, EPCOut=0.
- mtc0 SR=32'h0000_FC01, then HWInt=6'b000100 -> Req=1 in the same cycle. Next cycle: Cause=32'h0000_1000 (ExcCode 0, IP[12] set), EXL=1, Req=0, EPC = PC of the M-stage instruction.
- ExcCodeIn=12 (Ov), BDIn=1, PC=32'h0000_3010 -> Req=1. Then EPC=32'h0000_300C, Cause[31]=1, Cause[6:2]=12. A second exception while EXL=1 -> Req=0 and EPC unchanged.
- Same cycle ExcCodeIn=8 and an enabled interrupt -> ExcCode recorded is 0 (interrupt wins).
- mtc0 EPC=32'h0000_3003 with eret in the following cycle -> EPCOut=32'h0000_3000 in the mtc0 cycle, and EXL clears after the eret posedge.
- With CP0_TIMER_EN: mtc0 Compare=5, Count=0, SR IM[15]=1, IE=1 -> Req asserts once Count reaches 5. A Compare write clears TI.

Source files
------------

// File: rtl/cp0_unit_pkg.sv
// cp0_unit_pkg: shared constants for the coprocessor-0 slice.
//   - CP0 register numbers (Rd field of mtc0/mfc0)
//   - exception codes recorded in Cause.ExcCode
//   - SR / Cause field bit positions
package cp0_unit_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IM_LO     = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_BD_BIT = 31;

endpackage

// File: rtl/cp0_unit_if.sv
// cp0_unit_if: M-stage side of CP0.
//   master (pipeline): drives Addr, WriteData, CP0Write, PC, BDIn, ExcCodeIn,
//                      EretIn, HWInt; receives Req, EPCOut, HandlerPC, ReadData
//   slave  (cp0_unit): the reverse
interface cp0_unit_if;
  logic [4:0]  Addr;
  logic [31:0] WriteData;
  logic        CP0Write;
  logic [31:0] PC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic        EretIn;
  logic [5:0]  HWInt;
  logic        Req;
  logic [31:0] EPCOut;
  logic [31:0] HandlerPC;
  logic [31:0] ReadData;

  modport master (
    output Addr, WriteData, CP0Write, PC, BDIn, ExcCodeIn, EretIn, HWInt,
    input  Req, EPCOut, HandlerPC, ReadData
  );

  modport slave (
    input  Addr, WriteData, CP0Write, PC, BDIn, ExcCodeIn, EretIn, HWInt,
    output Req, EPCOut, HandlerPC, ReadData
  );
endinterface

// File: rtl/cp0_unit_timer.sv
// cp0_timer: Count (reg 9) / Compare (reg 11) pair with timer-interrupt flag.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   wr_en       - mtc0 accepted this cycle (already gated by Req)
//   addr, wdata - mtc0 register number and data
//   count       - free-running counter, wraps at 2^32
//   compare     - compare value
//   ti          - timer interrupt flag, cleared by a Compare write
module cp0_timer
  import cp0_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [31:0] count_inc;
  assign count_inc = count + 32'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      // a software write to Count replaces this cycle's increment
      if (wr_en && addr == REG_COUNT) count <= wdata;
      else                            count <= count_inc;

      // a Compare write acknowledges the interrupt and wins over a new match
      if (wr_en && addr == REG_COMPARE) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (count_inc == compare) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor 0 at the M stage of the 5-stage MIPS pipeline.
// Holds SR (12), Cause (13) and EPC (14), samples HWInt, raises Req to flush
// the pipeline and redirect to HandlerPC, services mtc0/mfc0/eret.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - cp0_unit_if.slave (M-stage inputs, Req/EPCOut/HandlerPC/ReadData)
// Build option: define CP0_TIMER_EN to add Count (9) / Compare (11) and the
// timer interrupt folded onto interrupt line 5.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] EPC_RESET  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  cp0_unit_if.slave   bus
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        ti;
  logic [5:0]  hw_eff;
  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [31:0] epc_src;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic [31:0] read_data;

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_wr;

  // mtc0 from an instruction being flushed must not land
  assign timer_wr = bus.CP0Write & ~req;

  cp0_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (timer_wr),
    .addr    (bus.Addr),
    .wdata   (bus.WriteData),
    .count   (count),
    .compare (compare),
    .ti      (ti)
  );
`else
  assign ti = 1'b0;
`endif

  assign hw_eff  = bus.HWInt | {ti, 5'b0_0000};
  assign int_req = (|(hw_eff & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = (bus.ExcCodeIn != 5'd0) & ~sr_exl;
  assign req     = int_req | exc_req;

  // a delay-slot instruction restarts at its branch
  assign epc_src = bus.BDIn ? (bus.PC - 32'd4) : bus.PC;

  always_comb begin
    sr_val = '0;
    sr_val[SR_IM_LO +: 6] = sr_im;
    sr_val[SR_EXL_BIT]    = sr_exl;
    sr_val[SR_IE_BIT]     = sr_ie;
  end

  always_comb begin
    cause_val = '0;
    cause_val[CAUSE_BD_BIT]       = cause_bd;
    cause_val[CAUSE_IP_LO +: 6]   = cause_ip;
    cause_val[CAUSE_EXC_LO +: 5]  = cause_exc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= EPC_RESET;
    end else begin
      cause_ip <= hw_eff;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bus.BDIn;
        cause_exc <= int_req ? EXC_INT : bus.ExcCodeIn;
        epc       <= {epc_src[31:2], 2'b00};
      end else if (bus.EretIn) begin
        sr_exl <= 1'b0;
      end else if (bus.CP0Write) begin
        case (bus.Addr)
          REG_SR: begin
            sr_im  <= bus.WriteData[SR_IM_LO +: 6];
            sr_exl <= bus.WriteData[SR_EXL_BIT];
            sr_ie  <= bus.WriteData[SR_IE_BIT];
          end
          REG_EPC: epc <= {bus.WriteData[31:2], 2'b00};
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    read_data = '0;
    case (bus.Addr)
      REG_SR:      read_data = sr_val;
      REG_CAUSE:   read_data = cause_val;
      REG_EPC:     read_data = epc;
`ifdef CP0_TIMER_EN
      REG_COUNT:   read_data = count;
      REG_COMPARE: read_data = compare;
`endif
      default:     ;
    endcase
  end

  assign bus.Req       = req;
  assign bus.ReadData  = read_data;
  assign bus.HandlerPC = HANDLER_PC;
  // bypass so an eret right after mtc0 EPC returns to the new address
  assign bus.EPCOut    = (bus.CP0Write && bus.Addr == REG_EPC)
                         ? {bus.WriteData[31:2], 2'b00} : epc;

endmodule

// File: tb/tb_cp0_unit.sv
module tb_cp0_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cp0_unit_if bus ();

  cp0_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    bus.Addr = a;
    #1;
    chk(tag, bus.ReadData, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.Addr      = a;
    bus.WriteData = d;
    bus.CP0Write  = 1'b1;
    tick();
    bus.CP0Write  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.Addr = 5'd0; bus.WriteData = '0; bus.CP0Write = 1'b0; bus.PC = '0;
    bus.BDIn = 1'b0; bus.ExcCodeIn = 5'd0; bus.EretIn = 1'b0; bus.HWInt = 6'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;

    // reset state
    rd(5'd12, 32'h0, "rst_sr");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc");
    chk("rst_req", {31'b0, bus.Req}, 32'h0);
    chk("rst_epcout", bus.EPCOut, 32'h0);
    chk("handler_pc", bus.HandlerPC, 32'h0000_4180);

    // enable all interrupts, then raise HWInt[2]
    mtc0(5'd12, 32'h0000_FC01);
    rd(5'd12, 32'h0000_FC01, "sr_write");
    bus.HWInt = 6'b000100; bus.PC = 32'h0000_1000;
    rd(5'd13, 32'h0, "cause_pre_int");
    chk("int_req", {31'b0, bus.Req}, 32'h1);
    tick();
    rd(5'd13, 32'h0000_1000, "int_cause");
    chk("int_req_exl", {31'b0, bus.Req}, 32'h0);
    rd(5'd12, 32'h0000_FC03, "int_sr_exl");
    rd(5'd14, 32'h0000_1000, "int_epc");
    chk("int_epcout", bus.EPCOut, 32'h0000_1000);
    bus.HWInt = 6'd0;

    // eret clears EXL
    bus.EretIn = 1'b1; tick(); bus.EretIn = 1'b0;
    rd(5'd12, 32'h0000_FC01, "eret_sr");

    // overflow in a delay slot
    bus.ExcCodeIn = 5'd12; bus.BDIn = 1'b1; bus.PC = 32'h0000_3010;
    #1 chk("ov_req", {31'b0, bus.Req}, 32'h1);
    tick();
    bus.ExcCodeIn = 5'd0; bus.BDIn = 1'b0;
    rd(5'd14, 32'h0000_300C, "ov_epc");
    rd(5'd13, 32'h8000_0030, "ov_cause");

    // nested exception while EXL=1 is ignored
    bus.ExcCodeIn = 5'd10; bus.PC = 32'h0000_5000;
    #1 chk("nested_req", {31'b0, bus.Req}, 32'h0);
    tick();
    bus.ExcCodeIn = 5'd0;
    rd(5'd14, 32'h0000_300C, "nested_epc");
    rd(5'd13, 32'h8000_0030, "nested_cause");
    bus.EretIn = 1'b1; tick(); bus.EretIn = 1'b0;

    // interrupt + syscall + mtc0 EPC in one cycle: interrupt wins, mtc0 dropped
    bus.HWInt = 6'b000001; bus.ExcCodeIn = 5'd8; bus.PC = 32'h0000_2000;
    bus.Addr = 5'd14; bus.WriteData = 32'h0000_7777; bus.CP0Write = 1'b1;
    #1 chk("prio_req", {31'b0, bus.Req}, 32'h1);
    chk("prio_epcout_bypass", bus.EPCOut, 32'h0000_7774);
    tick();
    bus.CP0Write = 1'b0; bus.ExcCodeIn = 5'd0;
    rd(5'd13, 32'h0000_0400, "prio_cause");
    rd(5'd14, 32'h0000_2000, "prio_epc");
    bus.HWInt = 6'd0;

    // mtc0 EPC then eret: bypass and EXL clear
    bus.Addr = 5'd14; bus.WriteData = 32'h0000_3003; bus.CP0Write = 1'b1;
    #1 chk("bypass_epcout", bus.EPCOut, 32'h0000_3000);
    chk("bypass_readdata_old", bus.ReadData, 32'h0000_2000);
    tick();
    bus.CP0Write = 1'b0; bus.EretIn = 1'b1;
    #1 chk("eret_epcout", bus.EPCOut, 32'h0000_3000);
    chk("eret_req", {31'b0, bus.Req}, 32'h0);
    tick();
    bus.EretIn = 1'b0;
    rd(5'd12, 32'h0000_FC01, "eret2_sr");

    // Cause is read-only, SR unused bits read 0
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, 32'h0, "cause_ro");
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd(5'd12, 32'h0000_FC03, "sr_mask");

    // IM masking and IE gating
    mtc0(5'd12, 32'h0000_0401);
    bus.HWInt = 6'b000010;
    #1 chk("im_masked", {31'b0, bus.Req}, 32'h0);
    bus.HWInt = 6'b000001;
    #1 chk("im_enabled", {31'b0, bus.Req}, 32'h1);
    bus.HWInt = 6'd0;
    mtc0(5'd12, 32'h0000_0400);
    bus.HWInt = 6'b000001;
    #1 chk("ie_off", {31'b0, bus.Req}, 32'h0);
    bus.HWInt = 6'd0;

    rd(5'd20, 32'h0, "unmapped_reg");
`ifndef CP0_TIMER_EN
    mtc0(5'd9, 32'h1234_5678);
    rd(5'd9, 32'h0, "count_absent");
    mtc0(5'd11, 32'h1234_5678);
    rd(5'd11, 32'h0, "compare_absent");
`endif

    // asynchronous reset mid-operation
    mtc0(5'd12, 32'h0000_0401);
    bus.HWInt = 6'b000001;
    #1 chk("pre_reset_req", {31'b0, bus.Req}, 32'h1);
    reset = 1'b0;
    #1 chk("async_reset_req", {31'b0, bus.Req}, 32'h0);
    rd(5'd12, 32'h0, "async_reset_sr");
    rd(5'd14, 32'h0, "async_reset_epc");
    bus.HWInt = 6'd0;
    #1 reset = 1'b1;

`ifdef CP0_TIMER_EN
    begin
      bit seen;
      seen = 1'b0;
      mtc0(5'd9, 32'd0);
      mtc0(5'd11, 32'd5);
      mtc0(5'd12, 32'h0000_8001);
      for (int i = 0; i < 20; i++) begin
        if (bus.Req) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      chk("timer_req_seen", {31'b0, seen}, 32'h1);
      rd(5'd9, 32'd5, "timer_count_at_req");
      tick();
      rd(5'd13, 32'h0000_8000, "timer_cause_ip");
      mtc0(5'd11, 32'd100);
      rd(5'd11, 32'd100, "timer_compare_rd");
      tick();
      rd(5'd13, 32'h0, "timer_ti_cleared");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
